regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write enable, destination address, write data) between NREQ writeback requesters, e.g. ALU, load unit and exception/CSR unit.
- Uses a valid/ready handshake per requester and drives a registered write port, one write per cycle.
- Keeps a pending-write scoreboard of destination registers so issue logic can detect RAW hazards.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width (32 registers).
- DW, 32, register data width.

Ports:
- iClk  input  1  clock, all state updates on rising edge.
- iRst  input  1  asynchronous active-high reset.
- iReqValid  input  NREQ  requester i has a write pending.
- iReqAddr  input  NREQ*AW  packed destination addresses; requester i at bits [AW*i +: AW].
- iReqData  input  NREQ*DW  packed write data; requester i at bits [DW*i +: DW].
- oReqReady  output  NREQ  one-hot grant; requester i's write is accepted this cycle.
- iIssueValid  input  1  an instruction with a destination register issues this cycle.
- iIssueAddr  input  AW  destination of the issuing instruction.
- iFlush  input  1  clears the scoreboard (pipeline flush).
- oWrite  output  1  register-file write enable.
- oAddrC  output  AW  register-file write address.
- oRegC  output  DW  register-file write data.
- oPending  output  2**AW  scoreboard; bit r set means a write to register r is outstanding.

Behaviour:
- Reset (asynchronous, active-high):
  - oWrite=0, oAddrC=0, oRegC=0, oPending=0.
  - Round-robin pointer=0.
  - oReqReady is combinational and is 0 while iRst is high.
- Grant:
  - oReqReady is combinational from iReqValid and the priority pointer. At most one bit is set, and only for a valid requester.
  - With no valid requester, oReqReady=0.
  - A transfer occurs when iReqValid[i] and oReqReady[i] are both high. The requester must hold addr/data stable until it is granted.
- Priority:
  - Round-robin. The search starts at the pointer index and wraps from NREQ-1 to 0.
  - After a grant to i, the pointer becomes (i+1) mod NREQ. The pointer is unchanged when there is no grant.
- Latency:
  - A transfer in cycle N produces oWrite=1 with the granted addr/data during cycle N+1.
  - The register file latches at the end of N+1.
  - With no transfer in cycle N, oWrite=0 in N+1. oAddrC/oRegC hold their last values.
  - Back-to-back transfers are allowed: one per cycle, with no bubble.
- Register 0:
  - Is hard-wired zero in the register file.
  - A transfer to address 0 is accepted (ready asserted) but produces oWrite=0 in N+1.
- Scoreboard:
  - Set: on a rising edge with iIssueValid=1 and iIssueAddr!=0, set bit iIssueAddr.
  - Clear: on a rising edge with oWrite=1, clear bit oAddrC (the commit edge).
  - Simultaneous set and clear of the same address: set wins, because a new producer exists.
  - Set and clear of different addresses in the same cycle both apply.
  - iFlush=1: all bits clear at the edge, including a same-edge set.
  - iFlush does not cancel a write already in the output register or stop the handshake.
  - Bit 0 is always 0.
- Reset mid-operation:
  - An in-flight write held in the output register is dropped.
  - Requesters must re-present their writes after reset.

Optional Feature:
- Macro: WBARB_ROUND_ROBIN_EN.
- Defined: round-robin priority as described above.
- Undefined: fixed priority, with requester 0 highest and NREQ-1 lowest. The pointer register is not instantiated; all other behaviour is identical.

Test Plan:
- Reset: assert iRst with all requesters valid -> oReqReady=0, oWrite=0, oPending=0. After release, grant goes to requester 0.
- Single write: req1 valid, addr=5, data=0xDEADBEEF in cycle N -> oReqReady=3'b010 in N; oWrite=1, oAddrC=5, oRegC=0xDEADBEEF in N+1; oWrite=0 in N+2.
- Contention: all three requesters valid for 6 cycles (round-robin build) -> grants 0,1,2,0,1,2 with no idle cycle. Fixed-priority build: requester 0 is granted all 6 cycles.
- Register 0: req0 writes addr=0 -> ready=1 in N, oWrite=0 in N+1, oPending unchanged.
- Scoreboard: issue addr=7 -> oPending[7]=1. Later a write to 7 commits -> bit 7 clears after the commit edge. Issue addr=7 on the commit edge -> bit 7 stays 1.
- Flush: oPending bits 3 and 9 set, assert iFlush while a write to 3 is in the output register -> oPending=0, and the write to 3 still appears with oWrite=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one registered register-file write port between NREQ requesters and tracks pending writes.
// Define WBARB_ROUND_ROBIN_EN for round-robin priority; otherwise requester 0 has fixed highest priority.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic [NREQ-1:0]      iReqValid,
  input  logic [NREQ*AW-1:0]   iReqAddr,
  input  logic [NREQ*DW-1:0]   iReqData,
  output logic [NREQ-1:0]      oReqReady,
  input  logic                 iIssueValid,
  input  logic [AW-1:0]        iIssueAddr,
  input  logic                 iFlush,
  output logic                 oWrite,
  output logic [AW-1:0]        oAddrC,
  output logic [DW-1:0]        oRegC,
  output logic [2**AW-1:0]     oPending
);
  localparam int PW = $clog2(NREQ);
  localparam int NR = 2**AW;

  logic          gnt_any;
  logic [PW-1:0] gnt_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

`ifdef WBARB_ROUND_ROBIN_EN
  logic [PW-1:0] ptr_q, ptr_d;

  // Search starts at the pointer and wraps past NREQ-1 back to 0.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && iReqValid[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && iReqValid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end
`endif

  always_comb begin
    oReqReady = '0;
    if (gnt_any && !iRst) oReqReady[gnt_idx] = 1'b1;
  end

  assign sel_addr = iReqAddr[int'(gnt_idx)*AW +: AW];
  assign sel_data = iReqData[int'(gnt_idx)*DW +: DW];

  logic          write_q, write_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] data_q,  data_d;
  logic [NR-1:0] pend_q,  pend_d;

  // Writes to r0 are accepted but swallowed; addr/data hold on those.
  always_comb begin
    write_d = gnt_any && (sel_addr != '0);
    addr_d  = write_d ? sel_addr : addr_q;
    data_d  = write_d ? sel_data : data_q;
  end

  // Order matters: commit clear, then issue set (new producer wins), then flush.
  always_comb begin
    pend_d = pend_q;
    if (write_q) pend_d[addr_q] = 1'b0;
    if (iIssueValid && (iIssueAddr != '0)) pend_d[iIssueAddr] = 1'b1;
    if (iFlush) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  assign oWrite   = write_q;
  assign oAddrC   = addr_q;
  assign oRegC    = data_q;
  assign oPending = pend_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
`ifdef WBARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                iClk = 1'b0;
  logic                iRst;
  logic [NREQ-1:0]     iReqValid;
  logic [NREQ*AW-1:0]  iReqAddr;
  logic [NREQ*DW-1:0]  iReqData;
  logic [NREQ-1:0]     oReqReady;
  logic                iIssueValid;
  logic [AW-1:0]       iIssueAddr;
  logic                iFlush;
  logic                oWrite;
  logic [AW-1:0]       oAddrC;
  logic [DW-1:0]       oRegC;
  logic [2**AW-1:0]    oPending;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .iClk(iClk), .iRst(iRst), .iReqValid(iReqValid), .iReqAddr(iReqAddr),
    .iReqData(iReqData), .oReqReady(oReqReady), .iIssueValid(iIssueValid),
    .iIssueAddr(iIssueAddr), .iFlush(iFlush), .oWrite(oWrite), .oAddrC(oAddrC),
    .oRegC(oRegC), .oPending(oPending)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int cyc; } wr_t;
  wr_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected one, in the expected cycle.
  always @(negedge iClk) begin
    if (!iRst && oWrite) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h cyc=%0d expected none", oAddrC, oRegC, cyc);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (oAddrC !== e.addr || oRegC !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=0x%0h cyc=%0d expected addr=%0d data=0x%0h cyc=%0d",
                   oAddrC, oRegC, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iReqAddr[i*AW +: AW] = a;
    iReqData[i*DW +: DW] = d;
  endtask

  // One cycle: check the grant, queue expected writes for granted requesters, advance past the edge.
  task automatic step(input logic [NREQ-1:0] exp_rdy, input bit push);
    #1;
    chk("ready", {61'd0, oReqReady}, {61'd0, exp_rdy});
    if (push)
      for (int i = 0; i < NREQ; i++)
        if (exp_rdy[i] && iReqAddr[i*AW +: AW] != '0) begin
          wr_t e;
          e.addr = iReqAddr[i*AW +: AW];
          e.data = iReqData[i*DW +: DW];
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
        end
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_pend(input string name, input logic [31:0] exp);
    chk(name, {32'd0, oPending}, {32'd0, exp});
  endtask

  initial begin
    iRst = 1'b1; iReqValid = '1; iReqAddr = '0; iReqData = '0;
    iIssueValid = 1'b0; iIssueAddr = '0; iFlush = 1'b0;
    set_req(0, 5'd1, 32'hA0A0_0001);
    set_req(1, 5'd2, 32'hA1A1_0002);
    set_req(2, 5'd3, 32'hA2A2_0003);
    #12;
    chk("rst_ready", {61'd0, oReqReady}, 64'd0);
    chk("rst_write", {63'd0, oWrite}, 64'd0);
    chk_pend("rst_pend", 32'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;

    // Contention, all three valid for six cycles
    for (int k = 0; k < 6; k++) step(RR ? (3'b001 << (k % 3)) : 3'b001, 1'b1);

    // Single write from requester 1
    iReqValid = 3'b010; set_req(1, 5'd5, 32'hDEAD_BEEF);
    step(3'b010, 1'b1);
    iReqValid = '0;
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);

    // Write to r0: accepted, no register-file write
    iReqValid = 3'b001; set_req(0, 5'd0, 32'h1234_5678);
    step(3'b001, 1'b1);
    iReqValid = '0;
    step(3'b000, 1'b1);
    chk_pend("r0_pend", 32'd0);

    // Scoreboard set / commit clear / different-address set+clear
    iIssueValid = 1'b1; iIssueAddr = 5'd7;
    step(3'b000, 1'b1);
    chk_pend("issue7", 32'h0000_0080);
    iIssueValid = 1'b0; iReqValid = 3'b100; set_req(2, 5'd7, 32'h0000_0077);
    step(3'b100, 1'b1);
    chk_pend("wr7_inflight", 32'h0000_0080);
    iReqValid = '0; iIssueValid = 1'b1; iIssueAddr = 5'd4;
    step(3'b000, 1'b1);
    chk_pend("commit7_set4", 32'h0000_0010);

    // Issue 7 on its own commit edge: set wins
    iIssueAddr = 5'd7;
    step(3'b000, 1'b1);
    chk_pend("reissue7", 32'h0000_0090);
    iIssueValid = 1'b0; iReqValid = 3'b100; set_req(2, 5'd7, 32'h0000_0078);
    step(3'b100, 1'b1);
    iReqValid = '0; iIssueValid = 1'b1; iIssueAddr = 5'd7;
    step(3'b000, 1'b1);
    chk_pend("set_wins", 32'h0000_0090);

    // Flush while a write to 3 sits in the output register
    iIssueAddr = 5'd3;
    step(3'b000, 1'b1);
    chk_pend("issue3", 32'h0000_0098);
    iIssueAddr = 5'd9; iReqValid = 3'b001; set_req(0, 5'd3, 32'h0000_0033);
    step(3'b001, 1'b1);
    chk_pend("issue9", 32'h0000_0298);
    iReqValid = '0; iFlush = 1'b1; iIssueAddr = 5'd12;
    step(3'b000, 1'b1);
    chk_pend("flush", 32'd0);
    iFlush = 1'b0; iIssueValid = 1'b0;
    step(3'b000, 1'b1);
    chk_pend("post_flush", 32'd0);

    // Reset mid-operation drops the in-flight write and the pointer
    iReqValid = 3'b010; set_req(1, 5'd10, 32'h0000_00AA);
    iIssueValid = 1'b1; iIssueAddr = 5'd11;
    step(3'b010, 1'b0);
    iRst = 1'b1; iIssueValid = 1'b0;
    #1;
    chk("midrst_write", {63'd0, oWrite}, 64'd0);
    chk_pend("midrst_pend", 32'd0);
    chk("midrst_ready", {61'd0, oReqReady}, 64'd0);
    @(posedge iClk); #1;
    iRst = 1'b0; iReqValid = 3'b111;
    step(3'b001, 1'b1);
    iReqValid = '0;
    step(3'b000, 1'b1);
    step(3'b000, 1'b1);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
